// File: rtl/alpha_nibble_mult.sv
// Alphabet-set nibble multiplier: consumes one multiplicand's pre-computed
// multiples (I*1/3/5/7) and shift-accumulates them one weight nibble per cycle.
module alpha_nibble_mult #(
  parameter int LOG2_WIDTH = 4,
  parameter int WIDTH      = 2**LOG2_WIDTH,
  parameter int WWIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH+2:0]        I1,
  input  logic [WIDTH+2:0]        I3,
  input  logic [WIDTH+2:0]        I5,
  input  logic [WIDTH+2:0]        I7,
  input  logic [WWIDTH-1:0]       w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH+WWIDTH-1:0] product,
  output logic                    busy
);

  localparam int NIB = WWIDTH / 4;
  localparam int BW  = WIDTH + 3;
  localparam int PW  = WIDTH + WWIDTH;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q;
  logic [BW-1:0]     i1_q, i3_q, i5_q, i7_q;
  logic [WWIDTH-1:0] w_q;
  logic [KW-1:0]     k_q;
  logic [PW-1:0]     acc_q, acc_d, product_q;
  logic              out_valid_q;

  logic [3:0]        nib, nib_apx;
  logic [BW-1:0]     sel;
  logic [1:0]        shamt;
  logic [PW-1:0]     term;

  always_comb begin
    nib     = 4'(w_q >> {k_q, 2'b00});
    // Odd nibbles above 7 have no alphabet encoding; round them down by one.
    nib_apx = (nib[3] && nib[0]) ? nib - 4'd1 : nib;
    sel     = '0;
    shamt   = '0;
    case (nib_apx)
      4'd1:    begin sel = i1_q; shamt = 2'd0; end
      4'd2:    begin sel = i1_q; shamt = 2'd1; end
      4'd3:    begin sel = i3_q; shamt = 2'd0; end
      4'd4:    begin sel = i1_q; shamt = 2'd2; end
      4'd5:    begin sel = i5_q; shamt = 2'd0; end
      4'd6:    begin sel = i3_q; shamt = 2'd1; end
      4'd7:    begin sel = i7_q; shamt = 2'd0; end
      4'd8:    begin sel = i1_q; shamt = 2'd3; end
      4'd10:   begin sel = i5_q; shamt = 2'd1; end
      4'd12:   begin sel = i3_q; shamt = 2'd2; end
      4'd14:   begin sel = i7_q; shamt = 2'd1; end
      default: begin sel = '0;   shamt = 2'd0; end
    endcase
    term  = (PW'(sel) << shamt) << {k_q, 2'b00};
    acc_d = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i1_q        <= '0;
      i3_q        <= '0;
      i5_q        <= '0;
      i7_q        <= '0;
      w_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            i1_q    <= I1;
            i3_q    <= I3;
            i5_q    <= I5;
            i7_q    <= I7;
            w_q     <= w;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == KW'(NIB - 1)) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_alpha_nibble_mult.sv
// Directed and randomized checks of alpha_nibble_mult against an arithmetic
// model: product = I * sum(approx(nibble_k) * 16^k).
module tb_alpha_nibble_mult;

  localparam int W   = 16;
  localparam int WW  = 8;
  localparam int NIB = WW / 4;
  localparam int BW  = W + 3;
  localparam int PW  = W + WW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] I1, I3, I5, I7;
  logic [WW-1:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  alpha_nibble_mult #(.LOG2_WIDTH(4), .WWIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .I1(I1), .I3(I3), .I5(I5), .I7(I7), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input longint unsigned iv, input int unsigned wv);
    longint unsigned acc = 0;
    for (int k = 0; k < NIB; k++) begin
      int unsigned n = (wv >> (4 * k)) & 15;
      if ((n % 2 == 1) && (n > 7)) n = n - 1;
      acc += iv * n * (longint'(1) << (4 * k));
    end
    return acc % (longint'(1) << PW);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive_ops(input logic [W-1:0] iv, input logic [WW-1:0] wv);
    I1 = BW'(iv);
    I3 = BW'(iv) * 3;
    I5 = BW'(iv) * 5;
    I7 = BW'(iv) * 7;
    w  = wv;
  endtask

  // One full transaction: accept, NIB compute edges, optional stall in DONE.
  task automatic run_op(input logic [W-1:0] iv, input logic [WW-1:0] wv, input int stall);
    logic [63:0] exp;
    exp = model(iv, wv);
    @(negedge clk);
    drive_ops(iv, wv);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_calc", busy, 1);
    for (int i = 1; i <= NIB; i++) begin
      check("in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      if (i < NIB) check("out_valid_early", out_valid, 0);
    end
    check("out_valid_latency", out_valid, 1);
    check("product", product, exp);
    check("in_ready_done", in_ready, 0);
    for (int j = 0; j < stall; j++) begin
      in_valid = 1'b1;
      drive_ops(W'($urandom), WW'($urandom));
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_product", product, exp);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);
    check("release_idle", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_ops('0, '0);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd100, 8'h35, 0);
    run_op(16'd1000, 8'hF9, 0);
    run_op(16'hFFFF, 8'hFF, 0);
    run_op(16'd7, 8'h00, 0);
    run_op(16'd7, 8'h80, 0);
    run_op(16'd1234, 8'h9B, 5);
    run_op(16'd4321, 8'h7D, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    drive_ops(16'd500, 8'hEE);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    run_op(16'd3, 8'h12, 0);

    for (int r = 0; r < 25; r++)
      run_op(W'($urandom), WW'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
